// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_queue                                                   |
// | Purpose  : Circular FIFO of single-instruction entries between a         |
// |            dual-issue fetch stage and decode. It accepts up to two        |
// |            instructions per cycle and presents the two oldest.            |
// |            pc_write gives backpressure to fetch, and flush empties the    |
// |            queue.                                                          |
// | Options  : `define FETCH_QUEUE_STATS_EN adds the stall_cycles and         |
// |            high_water statistics outputs.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     hlt,
  input  logic                     in_valid,
  input  logic                     in_valid2,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]   in_instr1,
  input  logic [INSTR_WIDTH-1:0]   in_instr2,
  output logic                     pc_write,
  output logic                     out_valid1,
  output logic [INSTR_WIDTH-1:0]   out_instr1,
  output logic [PC_WIDTH-1:0]      out_pc1,
  output logic                     out_valid2,
  output logic [INSTR_WIDTH-1:0]   out_instr2,
  output logic [PC_WIDTH-1:0]      out_pc2,
  input  logic [1:0]               deq_cnt,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [$clog2(DEPTH):0]   high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Room for a full pair is required before fetch may advance.
  localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - 2);

  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];

  logic          enq;
  logic [CW-1:0] enq_n;
  logic [1:0]    deq_req;
  logic [CW-1:0] deq_n;
  logic [AW-1:0] head_p1;

  // Backpressure depends only on registered occupancy, not on this cycle's dequeue.
  assign pc_write = !hlt && (count <= FILL_LIMIT);
  assign enq      = in_valid && pc_write && !flush;
  assign enq_n    = enq ? (in_valid2 ? CW'(2) : CW'(1)) : CW'(0);

  // Clamp the dequeue request to two and then to the current occupancy.
  always_comb begin
    deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
    deq_n   = (CW'(deq_req) > count) ? count : CW'(deq_req);
  end

  assign head_p1    = head + AW'(1);
  assign out_valid1 = (count >= CW'(1));
  assign out_valid2 = (count >= CW'(2));
  assign out_instr1 = instr_mem[head];
  assign out_pc1    = pc_mem[head];
  assign out_instr2 = instr_mem[head_p1];
  assign out_pc2    = pc_mem[head_p1];

  // Entry storage is write-only on enqueue and is never cleared.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[tail] <= in_instr1;
      pc_mem[tail]    <= in_pc;
      if (in_valid2) begin
        instr_mem[tail + AW'(1)] <= in_instr2;
        pc_mem[tail + AW'(1)]    <= in_pc + PC_WIDTH'(1);
      end
    end
  end

  // Pointer and occupancy update; flush takes priority over the enqueue and dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_n[AW-1:0];
      tail  <= tail + enq_n[AW-1:0];
      count <= count + enq_n - deq_n;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  // Statistics counters; flush leaves them intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      high_water   <= '0;
    end else begin
      if (in_valid && !pc_write && !flush && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (count > high_water)
        high_water <= count;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decouples the dual-issue fetch stage from decode.
- Receives two-instruction fetch bundles (instr1 at PC, instr2 at PC+1) plus the bundle PC, and buffers them in a circular FIFO of single-instruction entries.
- Presents up to two oldest instructions per cycle to decode.
- Drives pc_write back to fetch as backpressure and discards all contents on a branch-resolution flush.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, >= 4.
- PC_WIDTH, 16, PC width in bits.
- INSTR_WIDTH, 32, instruction width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  mispredict/branch redirect (PCSrc); empties the queue.
- hlt  input  1  halt; blocks enqueue and forces pc_write low.
- in_valid  input  1  fetch bundle present.
- in_valid2  input  1  second bundle slot valid (0 when slot 1 is a predicted-taken branch).
- in_pc  input  PC_WIDTH  PC of instr1.
- in_instr1  input  INSTR_WIDTH  first fetched instruction.
- in_instr2  input  INSTR_WIDTH  second fetched instruction.
- pc_write  output  1  fetch may advance; bundle accepted this cycle.
- out_valid1  output  1  head entry valid.
- out_instr1  output  INSTR_WIDTH  head instruction.
- out_pc1  output  PC_WIDTH  head PC.
- out_valid2  output  1  head+1 entry valid.
- out_instr2  output  INSTR_WIDTH  head+1 instruction.
- out_pc2  output  PC_WIDTH  head+1 PC.
- deq_cnt  input  2  instructions consumed by decode this cycle (0/1/2).
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- State: head pointer, tail pointer (each log2(DEPTH) bits, wrap modulo DEPTH), occupancy counter, and entry storage {instr, pc}.
- Reset (rst_n low, asynchronous): head=0, tail=0, count=0.
  - pc_write=1, out_valid1=0, out_valid2=0.
  - Entry storage is not cleared; out_instr*/out_pc* don't-care while invalid.
- pc_write = !hlt && (DEPTH - count >= 2). Combinational from registered count only; not a function of deq_cnt in the same cycle.
- Enqueue condition: in_valid && pc_write && !flush.
  - Write in_instr1/in_pc at tail.
  - If in_valid2, also write in_instr2 with pc = in_pc+1 (modulo 2^PC_WIDTH, wraps 16'hFFFF -> 16'h0000) at tail+1.
  - enq_n = 1 + in_valid2.
- Outputs are combinational reads of head and head+1:
  - out_valid1 = (count >= 1).
  - out_valid2 = (count >= 2).
- Dequeue: deq_n = min(deq_cnt, count), with deq_cnt=3 treated as 2. Excess requests are clipped silently. head advances by deq_n.
- Same-cycle enqueue and dequeue: count_next = count + enq_n - deq_n. Enqueued entries are not visible on out_* until the next cycle; there is no bypass.
- Flush (highest priority):
  - Next cycle head=tail=0 and count=0.
  - Enqueue and dequeue in the flush cycle are both discarded.
  - pc_write in the flush cycle still follows the formula above.
- hlt:
  - No enqueue and pc_write=0.
  - Dequeue continues normally, so the queue drains.
  - hlt && flush: flush wins, queue empties.
- Full boundary: at count = DEPTH-1 or DEPTH, pc_write=0 and in_valid is ignored.
- Empty boundary: at count=0, deq_cnt has no effect.
- Reset asserted mid-operation: immediate return to reset state, independent of clk.

Optional Feature:
FETCH_QUEUE_STATS_EN
- Defined: adds output ports `stall_cycles` (32-bit, saturating) and `high_water` (log2(DEPTH)+1 bits).
  - stall_cycles increments every cycle where in_valid=1 && pc_write=0 && !flush.
  - high_water holds the maximum count reached.
  - Both reset to 0 on rst_n low; flush does not clear them.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst_n low 2 cycles -> count=0, pc_write=1, out_valid1=0, out_valid2=0.
2. Pair enqueue: in_valid=1, in_valid2=1, in_pc=16'h0010, instr1=32'hAAAA0001, instr2=32'hBBBB0002, deq_cnt=0 -> next cycle count=2, out_pc1=16'h0010/32'hAAAA0001, out_pc2=16'h0011/32'hBBBB0002.
3. Fill to full: 4 pair bundles, DEPTH=8, no dequeue -> count=8, pc_write=0. A 5th bundle is dropped. deq_cnt=2 for 1 cycle -> count=6, pc_write=1.
4. Simultaneous traffic plus clipping:
   - count=1, enqueue a pair, deq_cnt=2 -> count=2 (deq clipped to 1). The old head is gone and the new pair sits at the head.
   - in_pc=16'hFFFF with in_valid2=1 -> second entry pc=16'h0000.
5. Flush priority: count=5, flush=1 with in_valid=1 and deq_cnt=2 -> next cycle count=0, out_valid1=0, nothing from that cycle enqueued.
6. Halt and async reset:
   - hlt=1, count=4, deq_cnt=1 for 4 cycles -> pc_write=0 throughout, count reaches 0.
   - rst_n low mid-cycle at count=3 -> count=0 before the next clk edge.
